// File: rtl/risc_operand_fetch.sv
// Operand fetch stage for the 8-bit RISC core: drives the registered register-file read ports,
// forwards writebacks that land on the same edge as the read, and hands operands to execute.
// Optional build macro RISC_FETCH_R0_ZERO_EN makes register 0 a hardwired zero.
module risc_operand_fetch #(
    parameter int CTRL_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_rs1_addr,
    input  logic [3:0]        in_rs2_addr,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_rs1,
    output logic [7:0]        out_rs2,
    output logic [CTRL_W-1:0] out_ctrl,
    input  logic              wb_valid,
    input  logic [3:0]        wb_addr,
    input  logic [7:0]        wb_data,
    output logic [3:0]        rf_rs1_addr,
    output logic [3:0]        rf_rs2_addr,
    input  logic [7:0]        rf_rs1,
    input  logic [7:0]        rf_rs2,
    output logic [3:0]        rf_rd_addr,
    output logic              rf_rd_write,
    output logic [7:0]        rf_rd
);

    logic              s1_valid_r;
    logic [3:0]        held_rs1_r;
    logic [3:0]        held_rs2_r;
    logic [CTRL_W-1:0] held_ctrl_r;
    logic              lw_valid_r;
    logic [3:0]        lw_addr_r;
    logic [7:0]        lw_data_r;
    logic              accept_s;
    logic              out_fire_s;

    // The register file returns the value from before a same-edge write; the last-write
    // register holds exactly that write, so it takes priority over the file's read data.
    function automatic logic [7:0] fwd_operand(
        input logic [3:0] addr,
        input logic [7:0] rf_val,
        input logic       lw_v,
        input logic [3:0] lw_a,
        input logic [7:0] lw_d
    );
        logic [7:0] val;
        if (lw_v && (lw_a == addr)) begin
            val = lw_d;
        end else begin
            val = rf_val;
        end
`ifdef RISC_FETCH_R0_ZERO_EN
        if (addr == 4'd0) begin
            val = 8'h00;
        end else begin
            val = val;
        end
`endif
        return val;
    endfunction

    assign in_ready   = !s1_valid_r || out_ready;
    assign accept_s   = in_valid && in_ready;
    assign out_fire_s = s1_valid_r && out_ready;
    assign out_valid  = s1_valid_r;

    // Read addressing: a new request goes straight to the file, otherwise keep re-reading the held pair.
    always_comb begin
        rf_rs1_addr = held_rs1_r;
        rf_rs2_addr = held_rs2_r;
        if (accept_s) begin
            rf_rs1_addr = in_rs1_addr;
            rf_rs2_addr = in_rs2_addr;
        end else begin
            rf_rs1_addr = held_rs1_r;
            rf_rs2_addr = held_rs2_r;
        end
    end

    // Write port passthrough; with the r0 option a write to r0 is suppressed entirely.
    always_comb begin
        rf_rd_addr = wb_addr;
        rf_rd      = wb_data;
`ifdef RISC_FETCH_R0_ZERO_EN
        if (wb_addr == 4'd0) begin
            rf_rd_write = 1'b0;
        end else begin
            rf_rd_write = wb_valid;
        end
`else
        rf_rd_write = wb_valid;
`endif
    end

    // Operand outputs, forced to zero while no request is held.
    always_comb begin
        out_rs1  = 8'h00;
        out_rs2  = 8'h00;
        out_ctrl = '0;
        if (s1_valid_r) begin
            out_rs1  = fwd_operand(held_rs1_r, rf_rs1, lw_valid_r, lw_addr_r, lw_data_r);
            out_rs2  = fwd_operand(held_rs2_r, rf_rs2, lw_valid_r, lw_addr_r, lw_data_r);
            out_ctrl = held_ctrl_r;
        end else begin
            out_rs1  = 8'h00;
            out_rs2  = 8'h00;
            out_ctrl = '0;
        end
    end

    // Request holding register and stage-valid flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r  <= 1'b0;
            held_rs1_r  <= 4'd0;
            held_rs2_r  <= 4'd0;
            held_ctrl_r <= '0;
        end else if (accept_s) begin
            s1_valid_r  <= 1'b1;
            held_rs1_r  <= in_rs1_addr;
            held_rs2_r  <= in_rs2_addr;
            held_ctrl_r <= in_ctrl;
        end else if (out_fire_s) begin
            s1_valid_r  <= 1'b0;
        end else begin
            s1_valid_r  <= s1_valid_r;
        end
    end

    // Last-write capture used by the bypass.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lw_valid_r <= 1'b0;
            lw_addr_r  <= 4'd0;
            lw_data_r  <= 8'h00;
        end else begin
            lw_valid_r <= rf_rd_write;
            lw_addr_r  <= wb_addr;
            lw_data_r  <= wb_data;
        end
    end

endmodule

// File: tb/tb_risc_operand_fetch.sv
// Directed bench for risc_operand_fetch with a behavioural registered-read register file.
module tb_risc_operand_fetch;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_rs1_addr;
    logic [3:0]  in_rs2_addr;
    logic [15:0] in_ctrl;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_rs1;
    logic [7:0]  out_rs2;
    logic [15:0] out_ctrl;
    logic        wb_valid;
    logic [3:0]  wb_addr;
    logic [7:0]  wb_data;
    logic [3:0]  rf_rs1_addr;
    logic [3:0]  rf_rs2_addr;
    logic [7:0]  rf_rs1;
    logic [7:0]  rf_rs2;
    logic [3:0]  rf_rd_addr;
    logic        rf_rd_write;
    logic [7:0]  rf_rd;

    logic [7:0]  mem [16];
    logic [7:0]  exp_rf [16];
    int          total_cnt;
    int          fail_cnt;

    risc_operand_fetch #(.CTRL_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr), .in_ctrl(in_ctrl),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_ctrl(out_ctrl),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
        .rf_rs1(rf_rs1), .rf_rs2(rf_rs2),
        .rf_rd_addr(rf_rd_addr), .rf_rd_write(rf_rd_write), .rf_rd(rf_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file: registered reads return the pre-write value on a same-edge write.
    always @(posedge clk) begin
        rf_rs1 <= mem[rf_rs1_addr];
        rf_rs2 <= mem[rf_rs2_addr];
        if (rf_rd_write) mem[rf_rd_addr] <= rf_rd;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total_cnt = 0;
        fail_cnt = 0;
        exp_rf = '{8'h00, 8'h21, 8'h32, 8'h43, 8'h10, 8'h00, 8'h76, 8'h87,
                   8'h98, 8'hA9, 8'hBA, 8'hCB, 8'hDC, 8'hED, 8'hFE, 8'h0F};
        rf_rs1 = 8'h00; rf_rs2 = 8'h00;
        rst_n = 1'b0; in_valid = 1'b0; in_rs1_addr = 4'd0; in_rs2_addr = 4'd0;
        in_ctrl = 16'h0000; out_ready = 1'b0; wb_valid = 1'b0; wb_addr = 4'd0; wb_data = 8'h00;
        #12;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_rs1", {24'd0, out_rs1}, 32'd0);
        chk("rst_out_ctrl", {16'd0, out_ctrl}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Preload r0..r15 through the writeback port (r0 written as 0 so the file is defined).
        for (int i = 0; i < 16; i++) begin
            wb_valid = 1'b1; wb_addr = i[3:0]; wb_data = exp_rf[i];
            #1;
            if (i == 6) begin
                chk("wb_pass_we", {31'd0, rf_rd_write}, 32'd1);
                chk("wb_pass_addr", {28'd0, rf_rd_addr}, 32'd6);
                chk("wb_pass_data", {24'd0, rf_rd}, 32'h76);
            end
            tick();
        end
        wb_valid = 1'b0;

        // Same-edge bypass: r3 <- 5A on the accept edge.
        in_valid = 1'b1; in_rs1_addr = 4'd3; in_rs2_addr = 4'd4; in_ctrl = 16'hA001;
        out_ready = 1'b1; wb_valid = 1'b1; wb_addr = 4'd3; wb_data = 8'h5A;
        #1;
        chk("byp_in_ready", {31'd0, in_ready}, 32'd1);
        chk("byp_rf_addr", {28'd0, rf_rs1_addr}, 32'd3);
        tick();
        exp_rf[3] = 8'h5A;
        in_valid = 1'b0; wb_valid = 1'b0;
        #1;
        chk("byp_valid", {31'd0, out_valid}, 32'd1);
        chk("byp_rs1", {24'd0, out_rs1}, 32'h5A);
        chk("byp_rs2", {24'd0, out_rs2}, 32'h10);
        chk("byp_ctrl", {16'd0, out_ctrl}, 32'hA001);
        tick();
        chk("byp_drain", {31'd0, out_valid}, 32'd0);
        chk("byp_idle_rs1", {24'd0, out_rs1}, 32'd0);

        // Streaming: request i reads rs1=r(i+1), rs2=r(15-i).
        for (int i = 0; i <= 8; i++) begin
            if (i < 8) begin
                in_valid = 1'b1; in_rs1_addr = 4'(i + 1); in_rs2_addr = 4'(15 - i);
                in_ctrl = 16'hC000 + 16'(i);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            chk("str_in_ready", {31'd0, in_ready}, 32'd1);
            if (i > 0) begin
                chk("str_valid", {31'd0, out_valid}, 32'd1);
                chk("str_rs1", {24'd0, out_rs1}, {24'd0, exp_rf[i]});
                chk("str_rs2", {24'd0, out_rs2}, {24'd0, exp_rf[16 - i]});
                chk("str_ctrl", {16'd0, out_ctrl}, 32'hC000 + 32'(i - 1));
            end
            tick();
        end
        chk("str_drain", {31'd0, out_valid}, 32'd0);

        // Stall tracking on r5 while writebacks land.
        in_valid = 1'b1; in_rs1_addr = 4'd1; in_rs2_addr = 4'd5; in_ctrl = 16'h5555;
        tick();
        in_rs1_addr = 4'd6; in_rs2_addr = 4'd7; in_ctrl = 16'h6666;
        out_ready = 1'b0; wb_valid = 1'b1; wb_addr = 4'd5; wb_data = 8'h11;
        #1;
        chk("stall_in_ready0", {31'd0, in_ready}, 32'd0);
        chk("stall_rs2_a", {24'd0, out_rs2}, 32'h00);
        tick();
        wb_data = 8'h22;
        #1;
        chk("stall_in_ready1", {31'd0, in_ready}, 32'd0);
        chk("stall_rs2_b", {24'd0, out_rs2}, 32'h11);
        tick();
        exp_rf[5] = 8'h22;
        wb_valid = 1'b0;
        #1;
        chk("stall_rs2_c", {24'd0, out_rs2}, 32'h22);
        chk("stall_held_addr", {28'd0, rf_rs2_addr}, 32'd5);
        chk("stall_ctrl", {16'd0, out_ctrl}, 32'h5555);
        tick();
        out_ready = 1'b1;
        #1;
        chk("stall_release_ready", {31'd0, in_ready}, 32'd1);
        chk("stall_release_rs2", {24'd0, out_rs2}, 32'h22);
        chk("stall_release_rs1", {24'd0, out_rs1}, {24'd0, exp_rf[1]});
        tick();
        in_valid = 1'b0;
        #1;
        chk("stall_next_valid", {31'd0, out_valid}, 32'd1);
        chk("stall_next_ctrl", {16'd0, out_ctrl}, 32'h6666);
        chk("stall_next_rs1", {24'd0, out_rs1}, 32'h76);
        chk("stall_next_rs2", {24'd0, out_rs2}, 32'h87);

        // Dual forward: both operands read r7 on the edge it is written.
        in_valid = 1'b1; in_rs1_addr = 4'd7; in_rs2_addr = 4'd7; in_ctrl = 16'h7777;
        wb_valid = 1'b1; wb_addr = 4'd7; wb_data = 8'hC3;
        tick();
        in_valid = 1'b0; wb_valid = 1'b0;
        #1;
        chk("dual_rs1", {24'd0, out_rs1}, 32'hC3);
        chk("dual_rs2", {24'd0, out_rs2}, 32'hC3);
        tick();

        // Back-to-back writes to r9; the request lands on the second one.
        wb_valid = 1'b1; wb_addr = 4'd9; wb_data = 8'h01;
        tick();
        wb_data = 8'h02; in_valid = 1'b1; in_rs1_addr = 4'd9; in_rs2_addr = 4'd2; in_ctrl = 16'h9999;
        tick();
        wb_valid = 1'b0; in_valid = 1'b0;
        #1;
        chk("b2b_rs1", {24'd0, out_rs1}, 32'h02);
        chk("b2b_rs2", {24'd0, out_rs2}, 32'h32);
        tick();

        // r0 handling.
        wb_valid = 1'b1; wb_addr = 4'd0; wb_data = 8'hFF;
        #1;
`ifdef RISC_FETCH_R0_ZERO_EN
        chk("r0_we", {31'd0, rf_rd_write}, 32'd0);
`else
        chk("r0_we", {31'd0, rf_rd_write}, 32'd1);
`endif
        tick();
        wb_valid = 1'b0; in_valid = 1'b1; in_rs1_addr = 4'd0; in_rs2_addr = 4'd1; in_ctrl = 16'h0F0F;
        tick();
        in_valid = 1'b0;
        #1;
`ifdef RISC_FETCH_R0_ZERO_EN
        chk("r0_rs1", {24'd0, out_rs1}, 32'h00);
`else
        chk("r0_rs1", {24'd0, out_rs1}, 32'hFF);
`endif
        chk("r0_rs2", {24'd0, out_rs2}, 32'h21);
        tick();

        // Reset mid-operation with a stalled result on the output.
        out_ready = 1'b0; in_valid = 1'b1; in_rs1_addr = 4'd8; in_rs2_addr = 4'd10; in_ctrl = 16'hBEEF;
        tick();
        in_valid = 1'b0;
        #1;
        chk("mid_valid_pre", {31'd0, out_valid}, 32'd1);
        chk("mid_rs1_pre", {24'd0, out_rs1}, 32'h98);
        wb_valid = 1'b1; wb_addr = 4'd11; wb_data = 8'h44;
        #1;
        rst_n = 1'b0;
        wb_valid = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_ready", {31'd0, in_ready}, 32'd1);
        chk("mid_rst_rs1", {24'd0, out_rs1}, 32'd0);
        chk("mid_rst_rs2", {24'd0, out_rs2}, 32'd0);
        chk("mid_rst_we", {31'd0, rf_rd_write}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        out_ready = 1'b1; in_valid = 1'b1; in_rs1_addr = 4'd10; in_rs2_addr = 4'd14; in_ctrl = 16'h1234;
        tick();
        in_valid = 1'b0;
        #1;
        chk("post_rst_rs1", {24'd0, out_rs1}, 32'hBA);
        chk("post_rst_rs2", {24'd0, out_rs2}, 32'hFE);
        chk("post_rst_ctrl", {16'd0, out_ctrl}, 32'h1234);
        tick();

        $display("%0d/%0d checks passed", total_cnt - fail_cnt, total_cnt);
        $finish;
    end

endmodule
